// File: rtl/lsu_biu_if.sv
// Load/store unit to bus interface unit signal bundle.
// Carries the address-generation handshake and the single-beat bus channel.
interface lsu_biu_if;
    logic        hs_ag4ls_val;
    logic        hs_ls4ag_rdy;
    logic [31:0] i_adr;
    logic [31:0] i_wdat;
    logic [3:0]  i_wen;
    logic        i_ren;
    logic [1:0]  i_ld_size;
    logic        i_ld_u;
    logic [31:0] o_rdat;
    logic        o_err;
    logic        o_bus_cmd_val;
    logic        i_bus_cmd_rdy;
    logic [31:0] o_bus_adr;
    logic [31:0] o_bus_wdat;
    logic [3:0]  o_bus_wen;
    logic        o_bus_ren;
    logic        i_bus_rsp_val;
    logic [31:0] i_bus_rsp_dat;
    logic        i_bus_rsp_err;

    modport slave (
        input  hs_ag4ls_val, i_adr, i_wdat, i_wen, i_ren,
        input  i_ld_size, i_ld_u,
        input  i_bus_cmd_rdy, i_bus_rsp_val, i_bus_rsp_dat,
        input  i_bus_rsp_err,
        output hs_ls4ag_rdy, o_rdat, o_err,
        output o_bus_cmd_val, o_bus_adr, o_bus_wdat,
        output o_bus_wen, o_bus_ren
    );

    modport master (
        output hs_ag4ls_val, i_adr, i_wdat, i_wen, i_ren,
        output i_ld_size, i_ld_u,
        output i_bus_cmd_rdy, i_bus_rsp_val, i_bus_rsp_dat,
        output i_bus_rsp_err,
        input  hs_ls4ag_rdy, o_rdat, o_err,
        input  o_bus_cmd_val, o_bus_adr, o_bus_wdat,
        input  o_bus_wen, o_bus_ren
    );
endinterface

// File: rtl/lsu_biu.sv
// Single-outstanding load/store bus interface unit.
// Shifts store data onto lanes and aligns/extends load responses.
module lsu_biu (
    input logic       clk,
    input logic       rst,
    lsu_biu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CMD, RSP, DONE} state_t;

    state_t      state;
    logic [31:0] adr_q;
    logic [31:0] wdat_q;
    logic [31:0] rdat_q;
    logic [3:0]  wen_q;
    logic [1:0]  size_q;
    logic        ren_q;
    logic        u_q;
    logic        err_q;
    logic        cmd_val_q;

    logic        is_wr;
    logic        is_acc;
    logic [2:0]  wcnt;
    logic [1:0]  st_size;
    logic [1:0]  acc_size;
    logic [31:0] wdat_sh;
    logic [31:0] b_sh;
    logic [31:0] h_sh;
    logic [31:0] ld_ext;

    assign is_wr  = |bus.i_wen;
    assign is_acc = is_wr | bus.i_ren;

    assign wcnt = {2'b00, bus.i_wen[0]} + {2'b00, bus.i_wen[1]}
                + {2'b00, bus.i_wen[2]} + {2'b00, bus.i_wen[3]};

    always_comb begin
        st_size = 2'd2;
        unique case (wcnt)
            3'd1:    st_size = 2'd0;
            3'd2:    st_size = 2'd1;
            default: st_size = 2'd2;
        endcase
    end

    assign acc_size = is_wr ? st_size : bus.i_ld_size;

    always_comb begin
        wdat_sh = bus.i_wdat;
        unique case (st_size)
            2'd0:    wdat_sh = {4{bus.i_wdat[7:0]}};
            2'd1:    wdat_sh = {2{bus.i_wdat[15:0]}};
            default: wdat_sh = bus.i_wdat;
        endcase
    end

    assign b_sh = bus.i_bus_rsp_dat >> {adr_q[1:0], 3'b000};
    assign h_sh = bus.i_bus_rsp_dat >> {adr_q[1], 4'b0000};

    // Stores return zero; only loads carry response data forward.
    always_comb begin
        ld_ext = bus.i_bus_rsp_dat;
        unique case (size_q)
            2'd0:    ld_ext = u_q ? {24'h0, b_sh[7:0]}
                                  : {{24{b_sh[7]}}, b_sh[7:0]};
            2'd1:    ld_ext = u_q ? {16'h0, h_sh[15:0]}
                                  : {{16{h_sh[15]}}, h_sh[15:0]};
            default: ld_ext = bus.i_bus_rsp_dat;
        endcase
        if (!ren_q) ld_ext = 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            adr_q     <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            wen_q     <= '0;
            size_q    <= '0;
            ren_q     <= 1'b0;
            u_q       <= 1'b0;
            err_q     <= 1'b0;
            cmd_val_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.hs_ag4ls_val && is_acc) begin
                        adr_q     <= bus.i_adr;
                        wdat_q    <= wdat_sh;
                        wen_q     <= bus.i_wen;
                        ren_q     <= bus.i_ren & ~is_wr;
                        size_q    <= acc_size;
                        u_q       <= bus.i_ld_u;
                        cmd_val_q <= 1'b1;
                        state     <= CMD;
                    end
                end
                CMD: begin
                    if (bus.i_bus_cmd_rdy) begin
                        cmd_val_q <= 1'b0;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (bus.i_bus_rsp_val) begin
                        rdat_q <= ld_ext;
                        err_q  <= bus.i_bus_rsp_err;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    rdat_q <= '0;
                    err_q  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // A flushed request still drains through DONE but never signals ready.
    assign bus.hs_ls4ag_rdy = bus.hs_ag4ls_val
                            & (((state == IDLE) & ~is_acc)
                               | (state == DONE));

    assign bus.o_rdat        = rdat_q;
    assign bus.o_err         = err_q;
    assign bus.o_bus_cmd_val = cmd_val_q;
    assign bus.o_bus_adr     = {adr_q[31:2], 2'b00};
    assign bus.o_bus_wdat    = wdat_q;
    assign bus.o_bus_wen     = wen_q;
    assign bus.o_bus_ren     = ren_q;
endmodule

// File: tb/tb_lsu_biu.sv
// Randomised and directed bench for lsu_biu.
// Expected values come from an arithmetic model of lane rules.
module tb_lsu_biu;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    lsu_biu_if bif ();

    lsu_biu dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_wdat(input logic [31:0] wd,
                                               input logic [3:0] wen);
        int n;
        n = $countones(wen);
        if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_rdat(input logic [31:0] adr,
                                               input logic [3:0] wen,
                                               input logic [1:0] sz,
                                               input logic u,
                                               input logic [31:0] rd);
        logic [31:0] v;
        if (wen != 4'b0) return 32'h0;
        if (sz == 2'd0) begin
            v = (rd >> (8 * (adr % 4))) & 32'hFF;
            return u ? v : (v ^ 32'h80) - 32'h80;
        end
        if (sz == 2'd1) begin
            v = (rd >> (16 * ((adr / 2) % 2))) & 32'hFFFF;
            return u ? v : (v ^ 32'h8000) - 32'h8000;
        end
        return rd;
    endfunction

    task automatic do_access(input logic [31:0] adr, input logic [31:0] wd,
                             input logic [3:0] wen, input logic ren,
                             input logic [1:0] sz, input logic u,
                             input int cdly, input int rdly,
                             input logic [31:0] rd, input logic re,
                             input logic flush, input logic noise,
                             input string nm);
        logic [31:0] e_wd, e_rd;
        logic        e_ren;
        int          lat;
        e_wd  = model_wdat(wd, wen);
        e_rd  = model_rdat(adr, wen, sz, u, rd);
        e_ren = (wen == 4'b0) ? ren : 1'b0;
        @(negedge clk);
        bif.hs_ag4ls_val = 1'b1;
        bif.i_adr = adr;
        bif.i_wdat = wd;
        bif.i_wen = wen;
        bif.i_ren = ren;
        bif.i_ld_size = sz;
        bif.i_ld_u = u;
        #1;
        checks++;
        if (bif.hs_ls4ag_rdy !== 1'b0)
            $display("FAIL %s accept_rdy: got %b want 0", nm,
                     bif.hs_ls4ag_rdy);
        if (bif.hs_ls4ag_rdy !== 1'b0) errors++;
        lat = 0;
        @(posedge clk);
        lat++;
        @(negedge clk);
        if (flush) bif.hs_ag4ls_val = 1'b0;
        for (int i = 0; i <= cdly; i++) begin
            checks++;
            if (bif.o_bus_cmd_val !== 1'b1
                || bif.o_bus_adr !== {adr[31:2], 2'b00}
                || bif.o_bus_wen !== wen || bif.o_bus_ren !== e_ren
                || (wen != 4'b0 && bif.o_bus_wdat !== e_wd)) begin
                errors++;
                $display("FAIL %s cmd[%0d]: val=%b adr=%h wen=%b ren=%b wd=%h want 1 %h %b %b %h",
                         nm, i, bif.o_bus_cmd_val, bif.o_bus_adr,
                         bif.o_bus_wen, bif.o_bus_ren, bif.o_bus_wdat,
                         {adr[31:2], 2'b00}, wen, e_ren, e_wd);
            end
            bif.i_bus_cmd_rdy = (i == cdly);
            bif.i_bus_rsp_val = noise && (i < cdly);
            bif.i_bus_rsp_dat = $urandom;
            bif.i_bus_rsp_err = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        bif.i_bus_cmd_rdy = 1'b0;
        for (int i = 0; i <= rdly; i++) begin
            checks++;
            if (bif.o_bus_cmd_val !== 1'b0 || bif.o_rdat !== 32'h0
                || bif.o_err !== 1'b0 || bif.hs_ls4ag_rdy !== 1'b0) begin
                errors++;
                $display("FAIL %s rsp_wait[%0d]: cval=%b rdat=%h err=%b rdy=%b want 0 0 0 0",
                         nm, i, bif.o_bus_cmd_val, bif.o_rdat, bif.o_err,
                         bif.hs_ls4ag_rdy);
            end
            bif.i_bus_rsp_val = (i == rdly);
            bif.i_bus_rsp_dat = (i == rdly) ? rd : $urandom;
            bif.i_bus_rsp_err = (i == rdly) ? re : 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        bif.i_bus_rsp_val = 1'b0;
        bif.i_bus_rsp_err = 1'b0;
        checks++;
        if (bif.hs_ls4ag_rdy !== !flush || bif.o_rdat !== e_rd
            || bif.o_err !== re || lat != 3 + cdly + rdly) begin
            errors++;
            $display("FAIL %s done: rdy=%b rdat=%h err=%b lat=%0d want %b %h %b %0d",
                     nm, bif.hs_ls4ag_rdy, bif.o_rdat, bif.o_err, lat,
                     !flush, e_rd, re, 3 + cdly + rdly);
        end
        bif.hs_ag4ls_val = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bif.o_rdat !== 32'h0 || bif.o_err !== 1'b0
            || bif.o_bus_cmd_val !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: rdat=%h err=%b cval=%b want 0 0 0",
                     nm, bif.o_rdat, bif.o_err, bif.o_bus_cmd_val);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bif.o_bus_cmd_val !== 1'b0 || bif.o_rdat !== 32'h0
            || bif.o_err !== 1'b0 || bif.hs_ls4ag_rdy !== 1'b0
            || bif.o_bus_wen !== 4'b0 || bif.o_bus_ren !== 1'b0) begin
            errors++;
            $display("FAIL reset: cval=%b rdat=%h err=%b rdy=%b wen=%b ren=%b want all 0",
                     bif.o_bus_cmd_val, bif.o_rdat, bif.o_err,
                     bif.hs_ls4ag_rdy, bif.o_bus_wen, bif.o_bus_ren);
        end
    endtask

    task automatic test_lb_signed();
        do_access(32'h1003, 32'h0, 4'b0000, 1'b1, 2'd0, 1'b0, 0, 0,
                  32'h80FF_0000, 1'b0, 1'b0, 1'b0, "lb_signed");
    endtask

    task automatic test_sh();
        do_access(32'h2002, 32'h0000_BEEF, 4'b1100, 1'b0, 2'd0, 1'b0, 0, 1,
                  32'h1234_5678, 1'b0, 1'b0, 1'b0, "sh");
    endtask

    task automatic test_no_access();
        @(negedge clk);
        bif.hs_ag4ls_val = 1'b1;
        bif.i_wen = 4'b0000;
        bif.i_ren = 1'b0;
        #1;
        checks++;
        if (bif.hs_ls4ag_rdy !== 1'b1 || bif.o_bus_cmd_val !== 1'b0) begin
            errors++;
            $display("FAIL no_access: rdy=%b cval=%b want 1 0",
                     bif.hs_ls4ag_rdy, bif.o_bus_cmd_val);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bif.hs_ls4ag_rdy !== 1'b1 || bif.o_bus_cmd_val !== 1'b0) begin
            errors++;
            $display("FAIL no_access_hold: rdy=%b cval=%b want 1 0",
                     bif.hs_ls4ag_rdy, bif.o_bus_cmd_val);
        end
        bif.hs_ag4ls_val = 1'b0;
    endtask

    task automatic test_stall_lhu();
        do_access(32'h0002, 32'h0, 4'b0000, 1'b1, 2'd1, 1'b1, 3, 0,
                  32'h8001_0000, 1'b0, 1'b0, 1'b1, "stall_lhu");
    endtask

    task automatic test_err();
        do_access(32'h0000_4000, 32'h0, 4'b0000, 1'b1, 2'd2, 1'b0, 1, 2,
                  32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, "rsp_err");
    endtask

    task automatic test_flush();
        do_access(32'h0000_0101, 32'h0, 4'b0000, 1'b1, 2'd0, 1'b0, 1, 1,
                  32'h0000_7F00, 1'b0, 1'b1, 1'b0, "flush");
    endtask

    task automatic test_reset_in_rsp();
        @(negedge clk);
        bif.hs_ag4ls_val = 1'b1;
        bif.i_adr = 32'h0000_3000;
        bif.i_wen = 4'b0000;
        bif.i_ren = 1'b1;
        bif.i_ld_size = 2'd2;
        @(posedge clk);
        @(negedge clk);
        bif.i_bus_cmd_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.i_bus_cmd_rdy = 1'b0;
        rst = 1'b1;
        bif.hs_ag4ls_val = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bif.hs_ls4ag_rdy !== 1'b0 || bif.o_bus_cmd_val !== 1'b0
            || bif.o_rdat !== 32'h0) begin
            errors++;
            $display("FAIL rst_in_rsp: rdy=%b cval=%b rdat=%h want 0 0 0",
                     bif.hs_ls4ag_rdy, bif.o_bus_cmd_val, bif.o_rdat);
        end
        bif.i_bus_rsp_val = 1'b1;
        bif.i_bus_rsp_dat = 32'hDEAD_BEEF;
        bif.i_bus_rsp_err = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.i_bus_rsp_val = 1'b0;
        bif.i_bus_rsp_err = 1'b0;
        checks++;
        if (bif.o_rdat !== 32'h0 || bif.o_err !== 1'b0
            || bif.hs_ls4ag_rdy !== 1'b0) begin
            errors++;
            $display("FAIL late_rsp: rdat=%h err=%b rdy=%b want 0 0 0",
                     bif.o_rdat, bif.o_err, bif.hs_ls4ag_rdy);
        end
        do_access(32'h0000_3001, 32'h0, 4'b0000, 1'b1, 2'd0, 1'b1, 0, 0,
                  32'h0000_AB00, 1'b0, 1'b0, 1'b0, "post_rst");
    endtask

    task automatic test_random();
        logic [3:0] wtab [7];
        logic [3:0] wen;
        logic [1:0] sz;
        logic       ren;
        wtab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                 4'b0011, 4'b1100, 4'b1111};
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 5) begin
                wen = 4'b0000;
                ren = 1'b1;
                sz  = 2'($urandom_range(0, 2));
            end else begin
                wen = wtab[$urandom_range(0, 6)];
                ren = 1'($urandom_range(0, 1));
                sz  = 2'($urandom_range(0, 3));
            end
            do_access($urandom, $urandom, wen, ren, sz,
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom, 1'($urandom_range(0, 7) == 0),
                      1'($urandom_range(0, 7) == 0),
                      1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bif.hs_ag4ls_val = 1'b0;
        bif.i_adr = '0;
        bif.i_wdat = '0;
        bif.i_wen = '0;
        bif.i_ren = 1'b0;
        bif.i_ld_size = '0;
        bif.i_ld_u = 1'b0;
        bif.i_bus_cmd_rdy = 1'b0;
        bif.i_bus_rsp_val = 1'b0;
        bif.i_bus_rsp_dat = '0;
        bif.i_bus_rsp_err = 1'b0;
        test_reset();
        test_lb_signed();
        test_sh();
        test_no_access();
        test_stall_lhu();
        test_err();
        test_flush();
        test_reset_in_rsp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
